cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4: number of cycles cpu_rst is held high before the CPU runs (legal values 1 to 255).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: number of cycles after halt before counters are sampled (legal values 0 to 15).
REQ-003 SHALL have parameter MAX_CYCLES, default 200000: run-cycle limit that triggers a timeout.
REQ-004 SHALL have port input_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run; honoured only in IDLE.
REQ-007 SHALL have port clear, input, 1 bit: returns the block from DONE to IDLE.
REQ-008 SHALL have port hlt_seen, input, 1 bit: CPU has decoded a hlt instruction (level or pulse).
REQ-009 SHALL have ports cpu_cycles, cpu_stalls, bp_count and bp_miss, input, 32 bits each: live CPU performance counters.
REQ-010 SHALL have port cpu_rst, output, 1 bit: reset to the CPU.
REQ-011 SHALL have port cpu_clk_en, output, 1 bit: CPU clock enable.
REQ-012 SHALL have port state, output, 3 bits: current state encoding.
REQ-013 SHALL have ports done and timeout, output, 1 bit each: run-complete flag and timeout flag.
REQ-014 SHALL have port run_cycles, output, 32 bits: number of RUN plus DRAIN cycles elapsed.
REQ-015 SHALL have ports snap_cycles, snap_stalls, snap_instr, snap_bp_count, snap_bp_hit and snap_bp_miss, output, 32 bits each: frozen statistics.

Function
REQ-016 SHALL implement the states IDLE=0, RST_HOLD=1, RUN=2, DRAIN=3 and DONE=4; the encodings 5 to 7 SHALL go to IDLE on the next cycle.
REQ-017 In IDLE: cpu_rst=1, cpu_clk_en=0; start=1 SHALL go to RST_HOLD, clear run_cycles, and clear done and timeout.
REQ-018 In RST_HOLD: cpu_rst=1, cpu_clk_en=1 for exactly RESET_CYCLES cycles, then go to RUN.
REQ-019 hlt_seen SHALL be ignored in RST_HOLD.
REQ-020 In RUN: cpu_rst=0, cpu_clk_en=1, and run_cycles increments by 1 every cycle.
REQ-021 In RUN, hlt_seen=1 SHALL go to DRAIN; with DRAIN_CYCLES=0 it SHALL go directly to DONE instead.
REQ-022 In RUN, when run_cycles reaches MAX_CYCLES-1 without hlt_seen, the block SHALL go to DONE with timeout=1.
REQ-023 If hlt_seen and the timeout condition occur in the same cycle, halt SHALL win: timeout=0 and the block follows the halt path.
REQ-024 In DRAIN: cpu_rst=0, cpu_clk_en=1, and run_cycles keeps incrementing; after DRAIN_CYCLES cycles the block SHALL go to DONE.
REQ-025 In DRAIN, further hlt_seen pulses SHALL be ignored.
REQ-026 On entry to DONE, all snap_* outputs SHALL be registered in one cycle from the counter values present on that edge.
REQ-027 Snapshot formulas SHALL be: snap_cycles = cpu_cycles+1 (accounts for the uncounted hlt); snap_stalls = cpu_stalls; snap_instr = cpu_cycles-cpu_stalls; snap_bp_count = bp_count; snap_bp_miss = bp_miss; snap_bp_hit = bp_count-bp_miss.
REQ-028 All snapshot arithmetic SHALL be 32-bit modulo with no saturation; snap_bp_hit wraps if bp_miss > bp_count.
REQ-029 In DONE: cpu_clk_en=0, cpu_rst=0, done=1, and snap_* held constant.
REQ-030 In DONE, start SHALL be ignored; clear=1 SHALL go to IDLE while done, timeout and snap_* retain their values until the next start.
REQ-031 run_cycles SHALL saturate at 0xFFFFFFFF.
REQ-032 start and clear SHALL be ignored in any state not named for them.

Reset
REQ-033 rst=1 on a clock edge SHALL force state=IDLE, cpu_rst=1, cpu_clk_en=0, done=0, timeout=0, run_cycles=0, and all snap_*=0, in any state including mid-run; rst has priority over every other input.

Verification
REQ-034 Nominal halt run: start, hlt_seen at run_cycles=100, cpu_cycles=120, cpu_stalls=20 sampled at DONE -> done=1, timeout=0, snap_cycles=121, snap_instr=100, DONE reached 4 cycles after DRAIN entry.
REQ-035 Timeout: MAX_CYCLES=50, hlt_seen never asserted -> DONE at run_cycles=49, timeout=1, done=1, cpu_clk_en=0 on the next cycle.
REQ-036 Simultaneous halt and timeout: hlt_seen on the same cycle as the limit -> DRAIN entered and timeout=0 at DONE.
REQ-037 Branch statistics: bp_count=40, bp_miss=10 -> snap_bp_hit=30; bp_count=0, bp_miss=0 -> snap_bp_hit=0 with no X values.
REQ-038 Reset mid-run: rst asserted in RUN at run_cycles=30 -> next cycle IDLE, cpu_rst=1, all outputs at reset values; a later start runs normally.
REQ-039 Ignored inputs and hold length: start pulses in RUN, DRAIN or DONE and hlt_seen in RST_HOLD -> no state change; cpu_rst stays high for exactly RESET_CYCLES cycles after start.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// CPU-side bundle of the run controller: CPU reset/clock-enable out, halt and live perf counters in.
interface cpu_run_controller_if;
  logic        cpu_rst;
  logic        cpu_clk_en;
  logic        hlt_seen;
  logic [31:0] cpu_cycles;
  logic [31:0] cpu_stalls;
  logic [31:0] bp_count;
  logic [31:0] bp_miss;

  modport master (
    output cpu_rst, cpu_clk_en,
    input  hlt_seen, cpu_cycles, cpu_stalls, bp_count, bp_miss
  );

  modport slave (
    input  cpu_rst, cpu_clk_en,
    output hlt_seen, cpu_cycles, cpu_stalls, bp_count, bp_miss
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Sequences one CPU run: reset hold, run until halt or cycle limit, drain, then freeze perf stats.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_CYCLES   = 200000
) (
  input  logic                        input_clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  cpu_run_controller_if.master        cpu,
  output logic [2:0]                  state,
  output logic                        done,
  output logic                        timeout,
  output logic [31:0]                 run_cycles,
  output logic [31:0]                 snap_cycles,
  output logic [31:0]                 snap_stalls,
  output logic [31:0]                 snap_instr,
  output logic [31:0]                 snap_bp_count,
  output logic [31:0]                 snap_bp_hit,
  output logic [31:0]                 snap_bp_miss
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] cycles;
    logic [31:0] stalls;
    logic [31:0] instr;
    logic [31:0] bp_count;
    logic [31:0] bp_hit;
    logic [31:0] bp_miss;
  } snap_t;

  state_t      state_q, state_d;
  snap_t       snap_q;
  logic [7:0]  phase_cnt;
  logic [31:0] run_inc;
  logic        limit_hit, count_en, timeout_set, enter_done;

  assign run_inc    = (run_cycles == '1) ? run_cycles : run_cycles + 32'd1;
  // Limit fires on the edge where the counter lands on MAX_CYCLES-1
  assign limit_hit  = (run_inc == 32'(MAX_CYCLES - 1));
  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    state_d        = state_q;
    cpu.cpu_rst    = 1'b1;
    cpu.cpu_clk_en = 1'b0;
    count_en       = 1'b0;
    timeout_set    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RST_HOLD;
      S_RST_HOLD: begin
        cpu.cpu_clk_en = 1'b1;
        if (phase_cnt == 8'(RESET_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        cpu.cpu_rst    = 1'b0;
        cpu.cpu_clk_en = 1'b1;
        count_en       = 1'b1;
        if (cpu.hlt_seen) begin
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (limit_hit) begin
          state_d     = S_DONE;
          timeout_set = 1'b1;
        end
      end
      S_DRAIN: begin
        cpu.cpu_rst    = 1'b0;
        cpu.cpu_clk_en = 1'b1;
        count_en       = 1'b1;
        if (phase_cnt == 8'(DRAIN_CYCLES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        cpu.cpu_rst = 1'b0;
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_cnt  <= '0;
      run_cycles <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      snap_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_cnt <= (state_d != state_q) ? 8'd0 : phase_cnt + 8'd1;
      if (state_q == S_IDLE && start) begin
        run_cycles <= '0;
        done       <= 1'b0;
        timeout    <= 1'b0;
      end
      if (count_en) run_cycles <= run_inc;
      if (enter_done) begin
        done             <= 1'b1;
        timeout          <= timeout_set;
        // +1 covers the hlt instruction the CPU never counts
        snap_q.cycles    <= cpu.cpu_cycles + 32'd1;
        snap_q.stalls    <= cpu.cpu_stalls;
        snap_q.instr     <= cpu.cpu_cycles - cpu.cpu_stalls;
        snap_q.bp_count  <= cpu.bp_count;
        snap_q.bp_hit    <= cpu.bp_count - cpu.bp_miss;
        snap_q.bp_miss   <= cpu.bp_miss;
      end
    end
  end

  assign state         = state_q;
  assign snap_cycles   = snap_q.cycles;
  assign snap_stalls   = snap_q.stalls;
  assign snap_instr    = snap_q.instr;
  assign snap_bp_count = snap_q.bp_count;
  assign snap_bp_hit   = snap_q.bp_hit;
  assign snap_bp_miss  = snap_q.bp_miss;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench: u_dut uses default parameters, u_to uses MAX_CYCLES=50 for limit scenarios.
module tb_cpu_run_controller;
  logic input_clk = 1'b0;
  logic rst, start, clear, start2, clear2;
  int   checks = 0;
  int   failures = 0;

  cpu_run_controller_if cif ();
  cpu_run_controller_if cif2 ();

  logic [2:0]  state, state2;
  logic        done, timeout, done2, timeout2;
  logic [31:0] run_cycles, snap_cycles, snap_stalls, snap_instr;
  logic [31:0] snap_bp_count, snap_bp_hit, snap_bp_miss;
  logic [31:0] run_cycles2, s2_cycles, s2_stalls, s2_instr, s2_bpc, s2_hit, s2_miss;

  always #5 input_clk = ~input_clk;

  cpu_run_controller u_dut (
    .input_clk(input_clk), .rst(rst), .start(start), .clear(clear), .cpu(cif.master),
    .state(state), .done(done), .timeout(timeout), .run_cycles(run_cycles),
    .snap_cycles(snap_cycles), .snap_stalls(snap_stalls), .snap_instr(snap_instr),
    .snap_bp_count(snap_bp_count), .snap_bp_hit(snap_bp_hit), .snap_bp_miss(snap_bp_miss)
  );

  cpu_run_controller #(.MAX_CYCLES(50)) u_to (
    .input_clk(input_clk), .rst(rst), .start(start2), .clear(clear2), .cpu(cif2.master),
    .state(state2), .done(done2), .timeout(timeout2), .run_cycles(run_cycles2),
    .snap_cycles(s2_cycles), .snap_stalls(s2_stalls), .snap_instr(s2_instr),
    .snap_bp_count(s2_bpc), .snap_bp_hit(s2_hit), .snap_bp_miss(s2_miss)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge input_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; clear = 0; start2 = 0; clear2 = 0;
    cif.hlt_seen = 0; cif.cpu_cycles = 0; cif.cpu_stalls = 0; cif.bp_count = 0; cif.bp_miss = 0;
    cif2.hlt_seen = 0; cif2.cpu_cycles = 0; cif2.cpu_stalls = 0; cif2.bp_count = 0; cif2.bp_miss = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({cif.cpu_rst, cif.cpu_clk_en} !== 2'b10) begin failures++; $display("FAIL reset_cpu_ctl got=%b exp=10", {cif.cpu_rst, cif.cpu_clk_en}); end
    checks++; if ({done, timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {done, timeout}); end
    checks++; if (run_cycles !== 32'd0 || snap_cycles !== 32'd0) begin failures++; $display("FAIL reset_counts run=%0h snap=%0h exp=0", run_cycles, snap_cycles); end
  endtask

  task automatic test_nominal_halt;
    cif.cpu_cycles = 120; cif.cpu_stalls = 20; cif.bp_count = 40; cif.bp_miss = 10;
    start = 1; tick(1); start = 0;
    // hold length with hlt_seen asserted during hold
    for (int i = 0; i < 4; i++) begin
      cif.hlt_seen = (i < 3);
      checks++; if (state !== 3'd1 || {cif.cpu_rst, cif.cpu_clk_en} !== 2'b11) begin failures++; $display("FAIL hold_cycle%0d state=%0d ctl=%b exp=1/11", i, state, {cif.cpu_rst, cif.cpu_clk_en}); end
      tick(1);
    end
    checks++; if (state !== 3'd2 || {cif.cpu_rst, cif.cpu_clk_en} !== 2'b01 || run_cycles !== 0) begin failures++; $display("FAIL run_entry state=%0d ctl=%b run=%0d exp=2/01/0", state, {cif.cpu_rst, cif.cpu_clk_en}, run_cycles); end
    start = 1; tick(1); start = 0;
    checks++; if (state !== 3'd2 || run_cycles !== 32'd1) begin failures++; $display("FAIL start_in_run state=%0d run=%0d exp=2/1", state, run_cycles); end
    tick(99);
    checks++; if (run_cycles !== 32'd100) begin failures++; $display("FAIL run_count got=%0d exp=100", run_cycles); end
    cif.hlt_seen = 1; tick(1); cif.hlt_seen = 0;
    checks++; if (state !== 3'd3 || run_cycles !== 32'd101) begin failures++; $display("FAIL drain_entry state=%0d run=%0d exp=3/101", state, run_cycles); end
    cif.hlt_seen = 1; start = 1; tick(1); cif.hlt_seen = 0; start = 0;
    tick(2);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL drain_len state=%0d exp=3", state); end
    tick(1);
    checks++; if (state !== 3'd4 || done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL done_entry state=%0d done=%b to=%b exp=4/1/0", state, done, timeout); end
    checks++; if ({cif.cpu_rst, cif.cpu_clk_en} !== 2'b00 || run_cycles !== 32'd105) begin failures++; $display("FAIL done_ctl ctl=%b run=%0d exp=00/105", {cif.cpu_rst, cif.cpu_clk_en}, run_cycles); end
    checks++; if (snap_cycles !== 32'd121 || snap_instr !== 32'd100 || snap_stalls !== 32'd20) begin failures++; $display("FAIL snap_main cyc=%0d instr=%0d stall=%0d exp=121/100/20", snap_cycles, snap_instr, snap_stalls); end
    checks++; if (snap_bp_count !== 32'd40 || snap_bp_hit !== 32'd30 || snap_bp_miss !== 32'd10) begin failures++; $display("FAIL snap_bp cnt=%0d hit=%0d miss=%0d exp=40/30/10", snap_bp_count, snap_bp_hit, snap_bp_miss); end
    cif.cpu_cycles = 999; start = 1; tick(1); start = 0;
    checks++; if (state !== 3'd4 || snap_cycles !== 32'd121) begin failures++; $display("FAIL done_hold state=%0d snap=%0d exp=4/121", state, snap_cycles); end
    clear = 1; tick(1); clear = 0;
    checks++; if (state !== 3'd0 || done !== 1'b1 || snap_cycles !== 32'd121) begin failures++; $display("FAIL clear state=%0d done=%b snap=%0d exp=0/1/121", state, done, snap_cycles); end
    tick(2);
    start = 1; tick(1); start = 0;
    checks++; if (state !== 3'd1 || done !== 1'b0 || run_cycles !== 0) begin failures++; $display("FAIL restart state=%0d done=%b run=%0d exp=1/0/0", state, done, run_cycles); end
    tick(4);
    cif.hlt_seen = 1; tick(1); cif.hlt_seen = 0;
    tick(4);
    clear = 1; tick(1); clear = 0;
  endtask

  task automatic test_branch_stats;
    logic [31:0] v [3][5];
    v[0] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    v[1] = '{32'd5, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd5};
    v[2] = '{32'd40, 32'd10, 32'd30, 32'hFFFF_FFFF, 32'd0};
    for (int k = 0; k < 3; k++) begin
      cif.bp_count = v[k][0]; cif.bp_miss = v[k][1]; cif.cpu_cycles = v[k][3]; cif.cpu_stalls = v[k][4];
      start = 1; tick(1); start = 0;
      tick(4);
      cif.hlt_seen = 1; tick(1); cif.hlt_seen = 0;
      tick(4);
      checks++; if (snap_bp_hit !== v[k][2]) begin failures++; $display("FAIL bp_hit_%0d got=%0h exp=%0h", k, snap_bp_hit, v[k][2]); end
      checks++; if (snap_cycles !== v[k][3] + 32'd1 || snap_instr !== v[k][3] - v[k][4]) begin failures++; $display("FAIL snap_wrap_%0d cyc=%0h instr=%0h", k, snap_cycles, snap_instr); end
      clear = 1; tick(1); clear = 0;
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1; tick(1); start = 0;
    tick(4 + 30);
    checks++; if (state !== 3'd2 || run_cycles !== 32'd30) begin failures++; $display("FAIL pre_rst state=%0d run=%0d exp=2/30", state, run_cycles); end
    rst = 1; tick(1); rst = 0;
    checks++; if (state !== 3'd0 || {cif.cpu_rst, cif.cpu_clk_en} !== 2'b10 || run_cycles !== 0) begin failures++; $display("FAIL mid_rst state=%0d ctl=%b run=%0d exp=0/10/0", state, {cif.cpu_rst, cif.cpu_clk_en}, run_cycles); end
    checks++; if ({done, timeout} !== 2'b00 || snap_cycles !== 0 || snap_bp_count !== 0 || snap_bp_hit !== 0) begin failures++; $display("FAIL mid_rst_snap flags=%b cyc=%0h bpc=%0h hit=%0h exp=0", {done, timeout}, snap_cycles, snap_bp_count, snap_bp_hit); end
    cif.cpu_cycles = 50; cif.cpu_stalls = 5;
    start = 1; tick(1); start = 0;
    tick(4);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL post_rst_run state=%0d exp=2", state); end
    cif.hlt_seen = 1; tick(1); cif.hlt_seen = 0;
    tick(4);
    checks++; if (done !== 1'b1 || snap_cycles !== 32'd51 || snap_instr !== 32'd45) begin failures++; $display("FAIL post_rst_done done=%b cyc=%0d instr=%0d exp=1/51/45", done, snap_cycles, snap_instr); end
  endtask

  task automatic test_timeout;
    start2 = 1; tick(1); start2 = 0;
    tick(4 + 48);
    checks++; if (state2 !== 3'd2 || run_cycles2 !== 32'd48) begin failures++; $display("FAIL to_pre state=%0d run=%0d exp=2/48", state2, run_cycles2); end
    tick(1);
    checks++; if (state2 !== 3'd4 || run_cycles2 !== 32'd49 || {done2, timeout2} !== 2'b11) begin failures++; $display("FAIL to_done state=%0d run=%0d flags=%b exp=4/49/11", state2, run_cycles2, {done2, timeout2}); end
    checks++; if (cif2.cpu_clk_en !== 1'b0) begin failures++; $display("FAIL to_clk_en got=%b exp=0", cif2.cpu_clk_en); end
    clear2 = 1; tick(1); clear2 = 0;
  endtask

  task automatic test_halt_vs_timeout;
    start2 = 1; tick(1); start2 = 0;
    checks++; if ({done2, timeout2} !== 2'b00) begin failures++; $display("FAIL hvt_start flags=%b exp=00", {done2, timeout2}); end
    tick(4 + 48);
    cif2.hlt_seen = 1; tick(1); cif2.hlt_seen = 0;
    checks++; if (state2 !== 3'd3 || timeout2 !== 1'b0) begin failures++; $display("FAIL hvt_drain state=%0d to=%b exp=3/0", state2, timeout2); end
    tick(4);
    checks++; if (state2 !== 3'd4 || {done2, timeout2} !== 2'b10 || run_cycles2 !== 32'd53) begin failures++; $display("FAIL hvt_done state=%0d flags=%b run=%0d exp=4/10/53", state2, {done2, timeout2}, run_cycles2); end
  endtask

  initial begin
    test_reset();
    test_nominal_halt();
    test_branch_stats();
    test_reset_mid_run();
    test_timeout();
    test_halt_vs_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
